// File: rtl/md_pkg.sv
// Shared encodings for the multiply/divide scheduler: op codes, FSM states
// and default latencies.
package md_pkg;

   typedef enum logic [3:0] {
      MD_MULT  = 4'd0,
      MD_MULTU = 4'd1,
      MD_DIV   = 4'd2,
      MD_DIVU  = 4'd3,
      MD_MADD  = 4'd4,
      MD_MADDU = 4'd5,
      MD_MSUB  = 4'd6,
      MD_MSUBU = 4'd7,
      MD_MTHI  = 4'd8,
      MD_MTLO  = 4'd9
   } md_op_e;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } md_state_e;

   localparam int unsigned MD_MULT_CYCLES_DEF = 5;
   localparam int unsigned MD_DIV_CYCLES_DEF  = 10;

   function automatic logic md_is_mult(input logic [3:0] op);
      return (op == MD_MULT)  || (op == MD_MULTU) ||
             (op == MD_MADD)  || (op == MD_MADDU) ||
             (op == MD_MSUB)  || (op == MD_MSUBU);
   endfunction

   function automatic logic md_is_div(input logic [3:0] op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational HI/LO arithmetic: products, multiply-accumulate and divide.
// Result layout is {hi, lo}; divides put the remainder in hi, quotient in lo.
module md_arith
   import md_pkg::*;
(
   input  logic [3:0]  op_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  logic [63:0] acc_i,
   output logic [63:0] res_o,
   output logic        div_by_zero_o
);

   logic [63:0] prod_s;
   logic [63:0] prod_u;
   logic        b_zero;
   logic [31:0] b_safe;
   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic [31:0] q_mag;
   logic [31:0] r_mag;
   logic [31:0] q_s;
   logic [31:0] r_s;
   logic [31:0] q_u;
   logic [31:0] r_u;

   assign prod_s = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
   assign prod_u = {32'd0, a_i} * {32'd0, b_i};

   // Divisor forced non-zero so the dividers never see 0; the result is
   // discarded by the zero flag in that case.
   assign b_zero = (b_i == 32'd0);
   assign b_safe = b_zero ? 32'd1 : b_i;

   // Signed divide via magnitudes: truncation toward zero and a remainder
   // carrying the dividend sign fall out naturally, including 0x80000000/-1.
   assign a_mag = a_i[31] ? (~a_i + 32'd1) : a_i;
   assign b_mag = b_safe[31] ? (~b_safe + 32'd1) : b_safe;
   assign q_mag = a_mag / b_mag;
   assign r_mag = a_mag % b_mag;
   assign q_s   = (a_i[31] ^ b_safe[31]) ? (~q_mag + 32'd1) : q_mag;
   assign r_s   = a_i[31] ? (~r_mag + 32'd1) : r_mag;

   assign q_u = a_i / b_safe;
   assign r_u = a_i % b_safe;

   always_comb begin
      res_o         = acc_i;
      div_by_zero_o = 1'b0;
      case (op_i)
         MD_MULT:  res_o = prod_s;
         MD_MULTU: res_o = prod_u;
         MD_MADD:  res_o = acc_i + prod_s;
         MD_MADDU: res_o = acc_i + prod_u;
         MD_MSUB:  res_o = acc_i - prod_s;
         MD_MSUBU: res_o = acc_i - prod_u;
         MD_DIV: begin
            div_by_zero_o = b_zero;
            res_o         = b_zero ? acc_i : {r_s, q_s};
         end
         MD_DIVU: begin
            div_by_zero_o = b_zero;
            res_o         = b_zero ? acc_i : {r_u, q_u};
         end
         default: res_o = acc_i;
      endcase
   end

endmodule

// File: rtl/md_sched.sv
// Multiply/divide scheduler: sequences multi-cycle HI/LO ops, owns the
// HI/LO registers and raises the D-stage stall while the unit is occupied.
//
// state | meaning
// IDLE  | no op in flight; MTHI/MTLO write directly, mult/div ops launch
// RUN   | result latched, cnt counting down; commit to HI/LO when cnt==1
module md_sched
   import md_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES_DEF,
   parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   input  logic        md_in_d,
   output logic        busy,
   output logic        stall_d,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   md_state_e   state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic [63:0] res_q, res_d;
   logic        dbz_q, dbz_d;

   logic [63:0] arith_res;
   logic        arith_dbz;

   md_arith u_arith (
      .op_i          (op),
      .a_i           (rs_val),
      .b_i           (rt_val),
      .acc_i         ({hi_q, lo_q}),
      .res_o         (arith_res),
      .div_by_zero_o (arith_dbz)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
         res_q   <= 64'd0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         res_q   <= res_d;
         dbz_q   <= dbz_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      res_d   = res_q;
      dbz_d   = dbz_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (op == MD_MTHI) begin
                  hi_d = rs_val;
               end else if (op == MD_MTLO) begin
                  lo_d = rs_val;
               end else if (md_is_mult(op)) begin
                  res_d   = arith_res;
                  dbz_d   = 1'b0;
                  cnt_d   = 4'(MULT_CYCLES);
                  state_d = RUN;
               end else if (md_is_div(op)) begin
                  res_d   = arith_res;
                  dbz_d   = arith_dbz;
                  cnt_d   = 4'(DIV_CYCLES);
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            // start is deliberately not looked at here; the stall keeps a
            // second HI/LO op out of E while we are busy.
            if (cnt_q == 4'd1) begin
               if (!dbz_q) begin
                  hi_d = res_q[63:32];
                  lo_d = res_q[31:0];
               end
               cnt_d   = 4'd0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy    = (state_q == RUN);
   assign stall_d = md_in_d & (start | busy);
   assign hi      = hi_q;
   assign lo      = lo_q;

endmodule
